as2650_mul_unit: RTL and testbench
==================================

AS2650_MUL_UNIT -- requirements
Module: as2650_mul_unit

Interface
REQ-001 SHALL have parameter: BITS_PER_CYCLE, 1, multiplier bits retired per iteration; legal values 1, 2, 4.
REQ-002 SHALL have port: wb_clk_i  in  1  sole clock; all state on rising edge.
REQ-003 SHALL have port: wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start  in  1  request a multiply with current operands.
REQ-005 SHALL have port: abort  in  1  cancel the operation in progress.
REQ-006 SHALL have port: op_a  in  8  multiplicand (core r0).
REQ-007 SHALL have port: op_b  in  8  multiplier (core r1).
REQ-008 SHALL have port: signed_i  in  1  signed-multiply request.
REQ-009 SHALL have port: busy  out  1  operation in progress.
REQ-010 SHALL have port: done  out  1  one-cycle completion pulse.
REQ-011 SHALL have port: res_lo  out  8  product bits 7:0 (written back to r0).
REQ-012 SHALL have port: res_hi  out  8  product bits 15:8 (written back to r1).
REQ-013 SHALL have port: cc  out  2  condition code for the product.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 SHALL, in IDLE or DONE with start=1 and abort=0, latch op_a, op_b and signed_i, clear the accumulator, and enter RUN.
REQ-016 SHALL take N = 8/BITS_PER_CYCLE iterations in RUN, one per edge: shift-add of BITS_PER_CYCLE multiplier bits into a 16-bit accumulator.
REQ-017 SHALL assert busy from the edge after start is sampled until the edge on which done rises.
REQ-018 SHALL drive done high for exactly one cycle, N edges after the start-sampling edge; state DONE lasts one cycle and then returns to IDLE.
REQ-019 SHALL update res_lo/res_hi/cc only on the edge that raises done, and hold them until the next completion.
REQ-020 SHALL compute the unsigned product modulo 2^16 (never overflows; 255*255 = 0xFE01).
REQ-021 SHALL set cc: 2'b00 if product == 0; 2'b10 if product bit 15 = 1; 2'b01 otherwise.
REQ-022 SHALL ignore start while in RUN; the latched operands do not change.
REQ-023 SHALL accept start in the DONE cycle (back-to-back); done still pulses for the finished operation.
REQ-024 SHALL, on abort=1 in RUN, return to IDLE on the next edge: busy low, no done pulse, result outputs keep their previous values.
REQ-025 SHALL give abort priority over a coincident start; abort in IDLE/DONE is a no-op.
REQ-026 SHALL ignore operand input changes after the start-sampling edge.

Reset
REQ-027 SHALL on wb_rst_i=1 immediately force IDLE, busy=0, done=0, res_lo=0, res_hi=0, cc=2'b00, accumulator and latches = 0.
REQ-028 SHALL discard an operation interrupted by reset and produce no done pulse.
REQ-029 SHALL accept start on the first rising edge after wb_rst_i deasserts.

Configuration
REQ-030 SHALL gate signed support with macro AS2650_MUL_SIGNED_EN.
REQ-031 SHALL, when it is defined and the latched signed_i=1, treat operands as two's complement and return the 16-bit signed product (sign correction on the final iteration, same latency N).
REQ-032 SHALL, when it is undefined, keep the signed_i port but ignore it; all products are unsigned.

Structure
REQ-033 SHALL place the FSM state enum, cc encodings (CC_ZERO, CC_POS, CC_NEG) and the legal BITS_PER_CYCLE values in package as2650_mul_pkg.
REQ-034 SHALL place the combinational BITS_PER_CYCLE partial-product add in sub-module as2650_mul_step; the FSM and registers remain in as2650_mul_unit.
REQ-035 SHALL flag an illegal BITS_PER_CYCLE at elaboration.

Verification
REQ-036 SHALL test op_a=50, op_b=10, start -> done after N edges: res_hi=0x01, res_lo=0xF4, cc=01.
REQ-037 SHALL test 0x00*0x37 -> result 0x0000, cc=00; 0xFF*0xFF unsigned -> 0xFE01, cc=10.
REQ-038 SHALL test start re-asserted with new operands mid-RUN -> ignored; the first result is delivered on schedule.
REQ-039 SHALL test abort two cycles after start -> busy low next edge, no done, previous result held; then 3*4 -> 0x000C.
REQ-040 SHALL test, with AS2650_MUL_SIGNED_EN and signed_i=1: 0xFF*0xFF -> 0x0001, cc=01; 0x80*0x01 -> 0xFF80, cc=10; the same stimulus without the macro -> 0xFE01 and 0x0080.
REQ-041 SHALL test 32 random operand pairs back-to-back at BITS_PER_CYCLE = 1, 2 and 4 -> each result equals a*b and each latency equals N.

Source files
------------

// File: rtl/as2650_mul_pkg.sv
// Shared definitions for the AS2650 iterative multiply unit: FSM states,
// condition-code encodings and the set of legal BITS_PER_CYCLE values.
package as2650_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    localparam logic [1:0] CC_ZERO = 2'b00;
    localparam logic [1:0] CC_POS  = 2'b01;
    localparam logic [1:0] CC_NEG  = 2'b10;

    localparam int unsigned LEGAL_BPC [3] = '{1, 2, 4};

    function automatic bit bpc_is_legal(input int unsigned bpc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (LEGAL_BPC[i] == bpc) ok = 1'b1;
        end
        return ok;
    endfunction

    // Bit 15 wins over the zero test only when non-zero, so order is irrelevant.
    function automatic logic [1:0] cc_of(input logic [15:0] prod);
        if (prod == 16'h0000)
            return CC_ZERO;
        else if (prod[15])
            return CC_NEG;
        else
            return CC_POS;
    endfunction

endpackage

// File: rtl/as2650_mul_step.sv
// One shift-add iteration: adds BITS_PER_CYCLE weighted copies of the
// multiplicand into the accumulator; the top bit may carry negative weight.
module as2650_mul_step #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [15:0]               acc,
    input  logic [15:0]               mcand,
    input  logic [BITS_PER_CYCLE-1:0] bits,
    input  logic                      neg_msb,
    output logic [15:0]               sum
);

    always_comb begin
        sum = acc;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (bits[i]) begin
                // Two's-complement multiplier: bit 7 has weight -2^7.
                if (neg_msb && (i == BITS_PER_CYCLE - 1))
                    sum = sum - (mcand << i);
                else
                    sum = sum + (mcand << i);
            end
        end
    end

endmodule

// File: rtl/as2650_mul_unit.sv
// AS2650 8x8 iterative multiplier, BITS_PER_CYCLE multiplier bits per edge.
// Define AS2650_MUL_SIGNED_EN to honour signed_i (two's-complement product).
module as2650_mul_unit
    import as2650_mul_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] op_a,
    input  logic [7:0] op_b,
    input  logic       signed_i,
    output logic       busy,
    output logic       done,
    output logic [7:0] res_lo,
    output logic [7:0] res_hi,
    output logic [1:0] cc
);

    localparam int N = 8 / BITS_PER_CYCLE;

    if (!bpc_is_legal(BITS_PER_CYCLE)) begin : g_bad_bpc
        $error("as2650_mul_unit: BITS_PER_CYCLE must be 1, 2 or 4");
    end

    mul_state_e  state;
    logic [15:0] acc;
    logic [15:0] mcand;
    logic [7:0]  mplier;
    logic [3:0]  cnt;
    logic [15:0] sum;
    logic        last;
    logic        neg_msb;
    logic [15:0] mcand_init;

`ifdef AS2650_MUL_SIGNED_EN
    logic sgn;
    assign mcand_init = {{8{signed_i & op_a[7]}}, op_a};
    assign neg_msb    = sgn & last;
`else
    logic unused_signed;
    assign unused_signed = signed_i;
    assign mcand_init    = {8'h00, op_a};
    assign neg_msb       = 1'b0;
`endif

    assign last = (cnt == 4'(N - 1));
    assign busy = (state == RUN);
    assign done = (state == DONE);

    as2650_mul_step #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_step (
        .acc     (acc),
        .mcand   (mcand),
        .bits    (mplier[BITS_PER_CYCLE-1:0]),
        .neg_msb (neg_msb),
        .sum     (sum)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            res_lo <= '0;
            res_hi <= '0;
            cc     <= CC_ZERO;
`ifdef AS2650_MUL_SIGNED_EN
            sgn    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start && !abort) begin
                        state  <= RUN;
                        acc    <= '0;
                        mcand  <= mcand_init;
                        mplier <= op_b;
                        cnt    <= '0;
`ifdef AS2650_MUL_SIGNED_EN
                        sgn    <= signed_i;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        acc    <= sum;
                        mcand  <= mcand << BITS_PER_CYCLE;
                        mplier <= mplier >> BITS_PER_CYCLE;
                        cnt    <= cnt + 4'd1;
                        // Results are published only on the completing edge.
                        if (last) begin
                            state  <= DONE;
                            res_lo <= sum[7:0];
                            res_hi <= sum[15:8];
                            cc     <= cc_of(sum);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_as2650_mul_unit.sv
// Directed and random checks of as2650_mul_unit at BITS_PER_CYCLE = 1, 2, 4.
module tb_as2650_mul_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       signed_i;
    logic       start_v  [3];
    logic       abort_v  [3];
    logic       busy_v   [3];
    logic       done_v   [3];
    logic [7:0] res_lo_v [3];
    logic [7:0] res_hi_v [3];
    logic [1:0] cc_v     [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        as2650_mul_unit #(.BITS_PER_CYCLE(1 << g)) u_dut (
            .wb_clk_i (clk),
            .wb_rst_i (rst),
            .start    (start_v[g]),
            .abort    (abort_v[g]),
            .op_a     (op_a),
            .op_b     (op_b),
            .signed_i (signed_i),
            .busy     (busy_v[g]),
            .done     (done_v[g]),
            .res_lo   (res_lo_v[g]),
            .res_hi   (res_hi_v[g]),
            .cc       (cc_v[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input int k, input logic [7:0] a, input logic [7:0] b, input logic s);
        op_a       = a;
        op_b       = b;
        signed_i   = s;
        start_v[k] = 1'b1;
        tick();
        start_v[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, inout int lat);
        while (done_v[k] !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_res(input string tag, input int k, input logic [15:0] prod, input logic [1:0] ccx);
        check({tag, "_prod"}, {res_hi_v[k], res_lo_v[k]}, prod);
        check({tag, "_cc"}, cc_v[k], ccx);
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s,
                          input logic [15:0] prod, input logic [1:0] ccx);
        int lat;
        start_op(0, a, b, s);
        check({tag, "_busy"}, busy_v[0], 1'b1);
        lat = 0;
        wait_done(0, lat);
        check({tag, "_lat"}, lat, 8);
        check_res(tag, 0, prod, ccx);
        tick();
        check({tag, "_done_once"}, done_v[0], 1'b0);
        check({tag, "_idle"}, busy_v[0], 1'b0);
    endtask

    initial begin
        int lat;
        int done_seen;
        logic [7:0] ra, rb;
        logic [15:0] ref_p;

        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b0;
            abort_v[k] = 1'b0;
        end
        op_a = 8'h00; op_b = 8'h00; signed_i = 1'b0;
        rst = 1'b1;
        #2;
        for (int k = 0; k < 3; k++) begin
            check("rst_busy", busy_v[k], 1'b0);
            check("rst_done", done_v[k], 1'b0);
            check_res("rst", k, 16'h0000, 2'b00);
        end
        tick(); tick();
        rst = 1'b0;

        // First edge after reset release accepts start.
        run_op("m50x10", 8'd50, 8'd10, 1'b0, 16'h01F4, 2'b01);
        run_op("zero", 8'h00, 8'h37, 1'b0, 16'h0000, 2'b00);
        run_op("ffff_u", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 2'b10);

        // start with new operands mid-RUN is ignored
        start_op(0, 8'd7, 8'd9, 1'b0);
        tick(); tick();
        op_a = 8'hAA; op_b = 8'h55; start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        lat = 3;
        wait_done(0, lat);
        check("midstart_lat", lat, 8);
        check_res("midstart", 0, 16'h003F, 2'b01);
        tick();

        // abort two cycles after start
        start_op(0, 8'h12, 8'h34, 1'b0);
        tick();
        abort_v[0] = 1'b1;
        tick();
        abort_v[0] = 1'b0;
        check("abort_busy", busy_v[0], 1'b0);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done_v[0] === 1'b1) done_seen++;
            tick();
        end
        check("abort_nodone", done_seen, 0);
        check_res("abort_hold", 0, 16'h003F, 2'b01);
        run_op("m3x4", 8'd3, 8'd4, 1'b0, 16'h000C, 2'b01);

        // abort coincident with start in IDLE blocks the start
        op_a = 8'd5; op_b = 8'd5;
        start_v[0] = 1'b1; abort_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0; abort_v[0] = 1'b0;
        check("abort_prio_busy", busy_v[0], 1'b0);

`ifdef AS2650_MUL_SIGNED_EN
        run_op("s_ffff", 8'hFF, 8'hFF, 1'b1, 16'h0001, 2'b01);
        run_op("s_80x01", 8'h80, 8'h01, 1'b1, 16'hFF80, 2'b10);
`else
        run_op("s_ffff", 8'hFF, 8'hFF, 1'b1, 16'hFE01, 2'b10);
        run_op("s_80x01", 8'h80, 8'h01, 1'b1, 16'h0080, 2'b01);
`endif

        // reset in the middle of an operation
        start_op(0, 8'd9, 8'd9, 1'b0);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", busy_v[0], 1'b0);
        check_res("midrst", 0, 16'h0000, 2'b00);
        tick();
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (done_v[0] === 1'b1) done_seen++;
            tick();
        end
        check("midrst_nodone", done_seen, 0);
        run_op("m2x3", 8'd2, 8'd3, 1'b0, 16'h0006, 2'b01);

        // 32 random back-to-back operations per configuration
        for (int k = 0; k < 3; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            start_op(k, ra, rb, 1'b0);
            for (int n = 0; n < 32; n++) begin
                ref_p = 16'(ra) * 16'(rb);
                lat = 0;
                wait_done(k, lat);
                check("rnd_lat", lat, 8 >> k);
                check("rnd_prod", {res_hi_v[k], res_lo_v[k]}, ref_p);
                if (n < 31) begin
                    ra = 8'($urandom_range(0, 255));
                    rb = 8'($urandom_range(0, 255));
                    start_op(k, ra, rb, 1'b0);
                    check("rnd_b2b_busy", busy_v[k], 1'b1);
                end else begin
                    tick();
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
